mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 13, width of all memory addresses.
REQ-002 Parameter: LINE_W, 32, width of refill read data.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset==0 at a rising edge of clk resets the block.
REQ-005 p0_rreq / p1_rreq  input  1  port read (refill) request, level, held until that port's rvalid.
REQ-006 p0_raddr / p1_raddr  input  ADDR_W  port refill block address.
REQ-007 p0_wreq / p1_wreq  input  1  port write-through request, level, held until that port's wack.
REQ-008 p0_waddr / p1_waddr  input  ADDR_W  port write byte address.
REQ-009 p0_wdata / p1_wdata  input  8  port write byte.
REQ-010 p0_rdata / p1_rdata  output  LINE_W  refill data returned to the port.
REQ-011 p0_rvalid / p1_rvalid  output  1  one-cycle pulse: refill data valid for that port.
REQ-012 p0_wack / p1_wack  output  1  one-cycle pulse: write accepted by memory for that port.
REQ-013 mem_rreq  output  1  read request to memory, level.
REQ-014 mem_raddr  output  ADDR_W  read address to memory.
REQ-015 mem_rdata  input  LINE_W  memory read data.
REQ-016 mem_rvalid  input  1  memory read data valid pulse.
REQ-017 mem_wreq / mem_waddr / mem_wdata  output  1 / ADDR_W / 8  write request, address, byte to memory.
REQ-018 mem_wack  input  1  memory write accept pulse.
REQ-019 gnt  output  2  one-hot current owner (bit0 port 0, bit1 port 1); 2'b00 when no owner.

Function
REQ-020 FSM states SHALL be IDLE, READ, WRITE, DONE; all outputs registered.
REQ-021 IDLE: a port is pending if its rreq or wreq is 1; no pending port -> stay IDLE.
REQ-022 One pending port -> grant it; both pending -> grant the port not granted last (round-robin pointer last_gnt).
REQ-023 Within the granted port, wreq SHALL take precedence over rreq in the same cycle.
REQ-024 Grant cycle N latches address/data of the granted port; at N+1 gnt is one-hot and mem_rreq (READ) or mem_wreq (WRITE) is 1 with latched values.
REQ-025 READ: hold mem_rreq=1 and mem_raddr constant until mem_rvalid==1; that cycle register mem_rdata, next cycle pulse granted port's rvalid for exactly 1 cycle with rdata, mem_rreq=0, go DONE.
REQ-026 WRITE: hold mem_wreq/mem_waddr/mem_wdata until mem_wack==1; next cycle pulse granted port's wack for 1 cycle, mem_wreq=0, go DONE.
REQ-027 DONE: one cycle, no grant, gnt=00, update last_gnt to finished port, then IDLE (masks the requester's registered request deassert).
REQ-028 Port rdata SHALL hold last refill value between pulses; non-granted port never sees rvalid/wack.
REQ-029 mem_rvalid or mem_wack outside READ/WRITE respectively SHALL be ignored.
REQ-030 Requester dropping its request mid-transaction: transaction completes normally, pulse still issued.
REQ-031 Latched address/data SHALL not change while in READ or WRITE regardless of port inputs.
REQ-032 Never mem_rreq and mem_wreq both 1; at most one transaction outstanding.

Reset
REQ-033 reset==0 SHALL force state IDLE, last_gnt=1 (port 0 wins first tie), gnt=00, all rvalid/wack/mem_rreq/mem_wreq=0, all address/data outputs 0.
REQ-034 reset asserted mid-READ/WRITE SHALL abort it with no rvalid/wack pulse; memory response arriving after reset release SHALL be ignored.

Verification
REQ-035 p0_rreq=1, p0_raddr=0x0A4; mem_rvalid after 3 cycles with mem_rdata=0xDEADBEEF -> mem_raddr=0x0A4, p0_rvalid one pulse, p0_rdata=0xDEADBEEF, gnt 01 then 00.
REQ-036 p0_rreq and p1_rreq both 1 from reset -> port 0 served first, then port 1 (gnt 01, 00, 10); repeat both -> order alternates.
REQ-037 p1_wreq=1, p1_waddr=0x1F03, p1_wdata=0x5A, mem_wack after 2 cycles -> mem_wdata=0x5A, mem_waddr=0x1F03, p1_wack one pulse, p0 outputs unchanged.
REQ-038 p0_wreq and p0_rreq same cycle -> write completes first, read granted after DONE.
REQ-039 reset=0 for 1 cycle while in READ, then mem_rvalid=1 -> no p0/p1_rvalid pulse, all outputs 0, state IDLE.
REQ-040 Stray mem_rvalid/mem_wack in IDLE -> no rvalid/wack pulse, gnt stays 00.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory.
// Each port issues refill reads (rreq/raddr) and write-through byte writes
// (wreq/waddr/wdata). Exactly one transaction is outstanding at a time.
// Ports:
//   clk, reset (sync, active-low)
//   p0_/p1_ rreq, raddr, wreq, waddr, wdata   : requester inputs
//   p0_/p1_ rdata, rvalid, wack               : requester responses
//   mem_rreq, mem_raddr, mem_rdata, mem_rvalid: memory read channel
//   mem_wreq, mem_waddr, mem_wdata, mem_wack  : memory write channel
//   gnt                                       : one-hot current owner
module mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int LINE_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_rreq,
  input  logic [ADDR_W-1:0] p0_raddr,
  input  logic              p0_wreq,
  input  logic [ADDR_W-1:0] p0_waddr,
  input  logic [7:0]        p0_wdata,
  input  logic              p1_rreq,
  input  logic [ADDR_W-1:0] p1_raddr,
  input  logic              p1_wreq,
  input  logic [ADDR_W-1:0] p1_waddr,
  input  logic [7:0]        p1_wdata,
  output logic [LINE_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  output logic              p0_wack,
  output logic [LINE_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic              p1_wack,
  output logic              mem_rreq,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wreq,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_wack,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state;
  logic   last_gnt;  // index of the port served most recently
  logic   cur;       // index of the port owning the current transaction

  logic              pend0;
  logic              pend1;
  logic              pick;
  logic              sel_wreq;
  logic [ADDR_W-1:0] sel_raddr;
  logic [ADDR_W-1:0] sel_waddr;
  logic [7:0]        sel_wdata;

  always_comb begin
    pend0 = p0_rreq | p0_wreq;
    pend1 = p1_rreq | p1_wreq;
    // On a tie the port that did not go last wins.
    if (pend0 && pend1) pick = ~last_gnt;
    else                pick = pend1;
    sel_wreq  = pick ? p1_wreq  : p0_wreq;
    sel_raddr = pick ? p1_raddr : p0_raddr;
    sel_waddr = pick ? p1_waddr : p0_waddr;
    sel_wdata = pick ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cur       <= 1'b0;
      gnt       <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_wack   <= 1'b0;
      p1_wack   <= 1'b0;
      mem_rreq  <= 1'b0;
      mem_raddr <= '0;
      mem_wreq  <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_wack   <= 1'b0;
      p1_wack   <= 1'b0;
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            cur <= pick;
            gnt <= pick ? 2'b10 : 2'b01;
            // Write beats read within the granted port.
            if (sel_wreq) begin
              mem_wreq  <= 1'b1;
              mem_waddr <= sel_waddr;
              mem_wdata <= sel_wdata;
              state     <= WRITE;
            end else begin
              mem_rreq  <= 1'b1;
              mem_raddr <= sel_raddr;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (mem_rvalid) begin
            mem_rreq <= 1'b0;
            gnt      <= '0;
            if (cur) begin
              p1_rdata  <= mem_rdata;
              p1_rvalid <= 1'b1;
            end else begin
              p0_rdata  <= mem_rdata;
              p0_rvalid <= 1'b1;
            end
            state <= DONE;
          end
        end
        WRITE: begin
          if (mem_wack) begin
            mem_wreq <= 1'b0;
            gnt      <= '0;
            if (cur) p1_wack <= 1'b1;
            else     p0_wack <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // One dead cycle so the finished requester's request can drop.
          last_gnt <= cur;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int LINE_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              p0_rreq, p0_wreq, p1_rreq, p1_wreq;
  logic [ADDR_W-1:0] p0_raddr, p0_waddr, p1_raddr, p1_waddr;
  logic [7:0]        p0_wdata, p1_wdata;
  logic [LINE_W-1:0] p0_rdata, p1_rdata;
  logic              p0_rvalid, p1_rvalid, p0_wack, p1_wack;
  logic              mem_rreq, mem_wreq;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [7:0]        mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rvalid, mem_wack;
  logic [1:0]        gnt;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .p0_rreq(p0_rreq), .p0_raddr(p0_raddr), .p0_wreq(p0_wreq),
    .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
    .p1_rreq(p1_rreq), .p1_raddr(p1_raddr), .p1_wreq(p1_wreq),
    .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
    .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_wack(p0_wack),
    .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_wack(p1_wack),
    .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .mem_wreq(mem_wreq), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wack(mem_wack), .gnt(gnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the memory, what kind of access,
  // and whether the one-cycle cooldown after completion is in progress.
  int                owner;      // -1 = nobody
  bit                own_write;
  bit                cooldown;
  int                last_port;
  logic [1:0]        m_gnt;
  bit                m_mem_rreq, m_mem_wreq;
  logic [ADDR_W-1:0] m_mem_raddr, m_mem_waddr;
  logic [7:0]        m_mem_wdata;
  logic [LINE_W-1:0] m_rdata [2];
  bit                m_rvalid [2];
  bit                m_wack [2];

  always @(posedge clk) begin
    bit                want_r [2];
    bit                want_w [2];
    logic [ADDR_W-1:0] ra [2];
    logic [ADDR_W-1:0] wa [2];
    logic [7:0]        wd [2];
    int                c;
    want_r[0] = p0_rreq; want_r[1] = p1_rreq;
    want_w[0] = p0_wreq; want_w[1] = p1_wreq;
    ra[0] = p0_raddr; ra[1] = p1_raddr;
    wa[0] = p0_waddr; wa[1] = p1_waddr;
    wd[0] = p0_wdata; wd[1] = p1_wdata;
    for (int i = 0; i < 2; i++) begin
      m_rvalid[i] = 1'b0;
      m_wack[i]   = 1'b0;
    end
    if (!reset) begin
      owner = -1; own_write = 1'b0; cooldown = 1'b0; last_port = 1;
      m_gnt = 2'b00; m_mem_rreq = 1'b0; m_mem_wreq = 1'b0;
      m_mem_raddr = '0; m_mem_waddr = '0; m_mem_wdata = '0;
      m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (cooldown) begin
      last_port = owner;
      owner = -1;
      cooldown = 1'b0;
    end else if (owner >= 0) begin
      if (own_write && mem_wack) begin
        m_wack[owner] = 1'b1;
        m_mem_wreq = 1'b0; m_gnt = 2'b00; cooldown = 1'b1;
      end else if (!own_write && mem_rvalid) begin
        m_rdata[owner] = mem_rdata;
        m_rvalid[owner] = 1'b1;
        m_mem_rreq = 1'b0; m_gnt = 2'b00; cooldown = 1'b1;
      end
    end else begin
      c = -1;
      if ((want_r[0] || want_w[0]) && (want_r[1] || want_w[1])) c = 1 - last_port;
      else if (want_r[0] || want_w[0]) c = 0;
      else if (want_r[1] || want_w[1]) c = 1;
      if (c >= 0) begin
        owner = c;
        m_gnt = 2'(1 << c);
        own_write = want_w[c];
        if (own_write) begin
          m_mem_wreq = 1'b1; m_mem_waddr = wa[c]; m_mem_wdata = wd[c];
        end else begin
          m_mem_rreq = 1'b1; m_mem_raddr = ra[c];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("gnt", 64'(gnt), 64'(m_gnt));
      chk("mem_rreq", 64'(mem_rreq), 64'(m_mem_rreq));
      chk("mem_wreq", 64'(mem_wreq), 64'(m_mem_wreq));
      chk("mem_raddr", 64'(mem_raddr), 64'(m_mem_raddr));
      chk("mem_waddr", 64'(mem_waddr), 64'(m_mem_waddr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_mem_wdata));
      chk("p0_rdata", 64'(p0_rdata), 64'(m_rdata[0]));
      chk("p1_rdata", 64'(p1_rdata), 64'(m_rdata[1]));
      chk("p0_rvalid", 64'(p0_rvalid), 64'(m_rvalid[0]));
      chk("p1_rvalid", 64'(p1_rvalid), 64'(m_rvalid[1]));
      chk("p0_wack", 64'(p0_wack), 64'(m_wack[0]));
      chk("p1_wack", 64'(p1_wack), 64'(m_wack[1]));
      chk("rreq_wreq_excl", 64'(mem_rreq & mem_wreq), 64'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    {p0_rreq, p0_wreq, p1_rreq, p1_wreq} = '0;
    p0_raddr = '0; p0_waddr = '0; p0_wdata = '0;
    p1_raddr = '0; p1_waddr = '0; p1_wdata = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    tick();
    check_en = 1'b1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_mem_rreq", 64'(mem_rreq), 64'd0);
    chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
    reset = 1'b1;

    // Single refill from port 0
    p0_rreq = 1'b1; p0_raddr = 13'h0A4;
    tick();
    chk("t35_gnt", 64'(gnt), 64'h1);
    chk("t35_mem_rreq", 64'(mem_rreq), 64'h1);
    chk("t35_mem_raddr", 64'(mem_raddr), 64'h0A4);
    p0_raddr = 13'h1FFF;  // must not disturb the latched address
    tick(); tick();
    chk("t35_raddr_held", 64'(mem_raddr), 64'h0A4);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t35_p0_rvalid", 64'(p0_rvalid), 64'h1);
    chk("t35_p0_rdata", 64'(p0_rdata), 64'hDEADBEEF);
    chk("t35_gnt_done", 64'(gnt), 64'h0);
    chk("t35_p1_rvalid", 64'(p1_rvalid), 64'h0);
    mem_rvalid = 1'b0; p0_rreq = 1'b0;
    tick();
    chk("t35_pulse_len", 64'(p0_rvalid), 64'h0);
    tick();

    // Tie from reset: port 0 first, then port 1, then alternate
    reset = 1'b0; tick(); reset = 1'b1;
    p0_rreq = 1'b1; p1_rreq = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
    tick(); chk("t36_first", 64'(gnt), 64'h1);
    tick(); chk("t36_p0_done", 64'(p0_rvalid), 64'h1); p0_rreq = 1'b0;
    tick(); chk("t36_gap", 64'(gnt), 64'h0);
    tick(); chk("t36_second", 64'(gnt), 64'h2);
    tick(); chk("t36_p1_done", 64'(p1_rvalid), 64'h1); p0_rreq = 1'b1;
    tick(); chk("t36_gap2", 64'(gnt), 64'h0);
    tick(); chk("t36_alt0", 64'(gnt), 64'h1);
    tick(); p0_rreq = 1'b0;
    tick();
    tick(); chk("t36_alt1", 64'(gnt), 64'h2);
    tick(); p1_rreq = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Write from port 1
    p1_wreq = 1'b1; p1_waddr = 13'h1F03; p1_wdata = 8'h5A;
    tick();
    chk("t37_gnt", 64'(gnt), 64'h2);
    chk("t37_mem_wreq", 64'(mem_wreq), 64'h1);
    chk("t37_mem_waddr", 64'(mem_waddr), 64'h1F03);
    chk("t37_mem_wdata", 64'(mem_wdata), 64'h5A);
    tick(); mem_wack = 1'b1;
    tick();
    chk("t37_p1_wack", 64'(p1_wack), 64'h1);
    chk("t37_p0_wack", 64'(p0_wack), 64'h0);
    chk("t37_p0_rvalid", 64'(p0_rvalid), 64'h0);
    mem_wack = 1'b0; p1_wreq = 1'b0;
    tick();

    // Write beats read on the same port
    p0_wreq = 1'b1; p0_rreq = 1'b1;
    p0_waddr = 13'h0222; p0_wdata = 8'h33; p0_raddr = 13'h0111;
    tick();
    chk("t38_wr_first", 64'(mem_wreq), 64'h1);
    chk("t38_no_rd", 64'(mem_rreq), 64'h0);
    mem_wack = 1'b1;
    tick(); chk("t38_wack", 64'(p0_wack), 64'h1);
    mem_wack = 1'b0; p0_wreq = 1'b0;
    tick();
    tick();
    chk("t38_rd_next", 64'(mem_rreq), 64'h1);
    chk("t38_raddr", 64'(mem_raddr), 64'h0111);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick(); chk("t38_rvalid", 64'(p0_rvalid), 64'h1);
    mem_rvalid = 1'b0; p0_rreq = 1'b0;
    tick();

    // Reset aborts an in-flight read; late response is ignored
    p0_rreq = 1'b1; p0_raddr = 13'h0055;
    tick(); tick();
    reset = 1'b0; p0_rreq = 1'b0;
    tick();
    chk("t39_gnt", 64'(gnt), 64'h0);
    chk("t39_mem_rreq", 64'(mem_rreq), 64'h0);
    chk("t39_mem_raddr", 64'(mem_raddr), 64'h0);
    reset = 1'b1; mem_rvalid = 1'b1;
    tick();
    chk("t39_no_rvalid", 64'(p0_rvalid), 64'h0);
    chk("t39_p0_rdata", 64'(p0_rdata), 64'h0);
    mem_rvalid = 1'b0;
    tick();

    // Stray memory responses while idle
    mem_rvalid = 1'b1; mem_wack = 1'b1;
    tick();
    chk("t40_gnt", 64'(gnt), 64'h0);
    chk("t40_pulses", 64'({p0_rvalid, p1_rvalid, p0_wack, p1_wack}), 64'h0);
    mem_rvalid = 1'b0; mem_wack = 1'b0;
    tick();

    // Random traffic with random memory latency, stray responses,
    // mid-transaction drops and occasional resets
    for (int n = 0; n < 4000; n++) begin
      if (p0_rvalid || ($urandom_range(63) == 0)) p0_rreq = 1'b0;
      else if (!p0_rreq && $urandom_range(3) == 0) p0_rreq = 1'b1;
      if (p0_wack || ($urandom_range(63) == 0)) p0_wreq = 1'b0;
      else if (!p0_wreq && $urandom_range(5) == 0) p0_wreq = 1'b1;
      if (p1_rvalid || ($urandom_range(63) == 0)) p1_rreq = 1'b0;
      else if (!p1_rreq && $urandom_range(3) == 0) p1_rreq = 1'b1;
      if (p1_wack || ($urandom_range(63) == 0)) p1_wreq = 1'b0;
      else if (!p1_wreq && $urandom_range(5) == 0) p1_wreq = 1'b1;
      p0_raddr = ADDR_W'($urandom); p0_waddr = ADDR_W'($urandom);
      p1_raddr = ADDR_W'($urandom); p1_waddr = ADDR_W'($urandom);
      p0_wdata = 8'($urandom); p1_wdata = 8'($urandom);
      mem_rdata = $urandom;
      mem_rvalid = ($urandom_range(2) == 0);
      mem_wack = ($urandom_range(2) == 0);
      reset = ($urandom_range(299) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
